// File: rtl/wb_queue_unit_pkg.sv
// Shared writeback definitions: opcode values, result-source classes and the classifier.
package wb_queue_unit_pkg;

    localparam int unsigned OPC_W = 8;
    localparam int unsigned RET_W = 16;

    localparam logic [OPC_W-1:0] OP_ADD_D     = 8'h01;
    localparam logic [OPC_W-1:0] OP_ADDI_D    = 8'h02;
    localparam logic [OPC_W-1:0] OP_AND_D     = 8'h03;
    localparam logic [OPC_W-1:0] OP_ANDI_D    = 8'h04;
    localparam logic [OPC_W-1:0] OP_MOV       = 8'h05;
    localparam logic [OPC_W-1:0] OP_MOVI_D    = 8'h06;
    localparam logic [OPC_W-1:0] OP_LDB       = 8'h07;
    localparam logic [OPC_W-1:0] OP_LDW       = 8'h08;
    localparam logic [OPC_W-1:0] OP_STW       = 8'h09;
    localparam logic [OPC_W-1:0] OP_JMP       = 8'h0A;
    localparam logic [OPC_W-1:0] OP_JSR       = 8'h0B;
    localparam logic [OPC_W-1:0] OP_JSRR      = 8'h0C;
    localparam logic [OPC_W-1:0] OP_BRN       = 8'h0D;
    localparam logic [OPC_W-1:0] OP_BRZ       = 8'h0E;
    localparam logic [OPC_W-1:0] OP_BRP       = 8'h0F;
    localparam logic [OPC_W-1:0] OP_BRNZP     = 8'h10;
    localparam logic [OPC_W-1:0] OP_VADD      = 8'h20;
    localparam logic [OPC_W-1:0] OP_VMOV      = 8'h21;
    localparam logic [OPC_W-1:0] OP_VMOVI     = 8'h22;
    localparam logic [OPC_W-1:0] OP_VCOMPMOV  = 8'h23;
    localparam logic [OPC_W-1:0] OP_VCOMPMOVI = 8'h24;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_SALU = 2'd1,
        WB_SMEM = 2'd2,
        WB_VEC  = 2'd3
    } wb_class_e;

    function automatic wb_class_e classify(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D, OP_MOV, OP_MOVI_D: classify = WB_SALU;
            OP_LDW, OP_LDB:                                              classify = WB_SMEM;
            OP_VADD, OP_VMOV, OP_VMOVI, OP_VCOMPMOV, OP_VCOMPMOVI:       classify = WB_VEC;
            OP_STW, OP_JMP, OP_JSR, OP_JSRR,
            OP_BRN, OP_BRZ, OP_BRP, OP_BRNZP:                            classify = WB_NONE;
            default:                                                     classify = WB_NONE;
        endcase
    endfunction

    // Component moves write only the lanes the instruction selects.
    function automatic logic uses_lane_mask(input logic [OPC_W-1:0] opc);
        return (opc == OP_VCOMPMOV) || (opc == OP_VCOMPMOVI);
    endfunction

endpackage

// File: rtl/wb_queue_unit_fifo.sv
// Generic WIDTH x DEPTH synchronous FIFO with occupancy counter and all-entry visibility.
module wb_queue_unit_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [DEPTH*WIDTH-1:0]     entries_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign count_o  = count_q;
    assign rd_ptr_o = rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: slots are only observed while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_vis
        assign entries_o[g*WIDTH +: WIDTH] = mem_q[g];
    end

endmodule

// File: rtl/wb_queue_unit.sv
// Writeback stage: classifies retiring instructions and queues register-file writes.
// Define WB_FWD_EN to add the combinational forwarding lookup over queued entries.
module wb_queue_unit
    import wb_queue_unit_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 16,
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned REGIDX_W  = 6,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                           I_CLOCK,
    input  logic                           I_RESET_N,
    input  logic                           I_Valid,
    output logic                           O_Ready,
    input  logic [OPC_W-1:0]               I_Opcode,
    input  logic [REGIDX_W-1:0]            I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]           I_ALUOut,
    input  logic [REG_WIDTH-1:0]           I_MemOut,
    input  logic [NUM_LANES*REG_WIDTH-1:0] I_VALUOut,
    input  logic [NUM_LANES-1:0]           I_LaneMask,
    output logic                           O_WbValid,
    input  logic                           I_WbReady,
    output logic                           O_WbIsVec,
    output logic [REGIDX_W-1:0]            O_WbRegIdx,
    output logic [REG_WIDTH-1:0]           O_WbData,
    output logic [NUM_LANES*REG_WIDTH-1:0] O_VWbData,
    output logic [NUM_LANES-1:0]           O_VWbMask,
    output logic [$clog2(DEPTH):0]         O_Pending,
`ifdef WB_FWD_EN
    input  logic [REGIDX_W-1:0]            I_FwdRegIdx,
    input  logic                           I_FwdIsVec,
    output logic                           O_FwdHit,
    output logic [REG_WIDTH-1:0]           O_FwdData,
    output logic [NUM_LANES*REG_WIDTH-1:0] O_VFwdData,
`endif
    output logic [RET_W-1:0]               O_RetireCnt
);

    localparam int unsigned VEC_W     = NUM_LANES * REG_WIDTH;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned MASK_LSB  = 0;
    localparam int unsigned VDATA_LSB = MASK_LSB + NUM_LANES;
    localparam int unsigned SDATA_LSB = VDATA_LSB + VEC_W;
    localparam int unsigned IDX_LSB   = SDATA_LSB + REG_WIDTH;
    localparam int unsigned ISVEC_BIT = IDX_LSB + REGIDX_W;
    localparam int unsigned ENTRY_W   = ISVEC_BIT + 1;

    wb_class_e              cls_c;
    logic                   accept_c, push_c, pop_c, is_vec_c;
    logic [NUM_LANES-1:0]   mask_c;
    logic [REG_WIDTH-1:0]   sdata_c;
    logic [VEC_W-1:0]       vdata_c;
    logic [ENTRY_W-1:0]     din_c, head_c;
    logic [ENTRY_W-1:0]     ent_c [DEPTH];
    logic                   full, empty;
    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       rd_ptr;
    logic [DEPTH*ENTRY_W-1:0] entries;
    logic [RET_W-1:0]       retire_q, retire_d;

    // Result-source selection and push decision for the instruction on the MEM interface.
    always_comb begin
        cls_c    = classify(I_Opcode);
        is_vec_c = (cls_c == WB_VEC);
        mask_c   = '0;
        sdata_c  = '0;
        vdata_c  = '0;
        if (is_vec_c) begin
            mask_c  = uses_lane_mask(I_Opcode) ? I_LaneMask : '1;
            vdata_c = I_VALUOut;
        end else if (cls_c == WB_SALU) begin
            sdata_c = I_ALUOut;
        end else if (cls_c == WB_SMEM) begin
            sdata_c = I_MemOut;
        end
        accept_c = I_Valid && O_Ready;
        push_c   = accept_c && (cls_c != WB_NONE) && !(is_vec_c && (mask_c == '0));
        din_c    = {is_vec_c, I_DestRegIdx, sdata_c, vdata_c, mask_c};
    end

    assign pop_c = !empty && I_WbReady;

    wb_queue_unit_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (I_CLOCK),
        .rst_n     (I_RESET_N),
        .push_i    (push_c),
        .din_i     (din_c),
        .pop_i     (pop_c),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count),
        .rd_ptr_o  (rd_ptr),
        .entries_o (entries)
    );

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_ent
        assign ent_c[g] = entries[g*ENTRY_W +: ENTRY_W];
    end

    assign head_c      = ent_c[rd_ptr];
    assign O_Ready     = !full;
    assign O_Pending   = count;
    assign O_WbValid   = !empty;
    assign O_WbIsVec   = !empty && head_c[ISVEC_BIT];
    assign O_WbRegIdx  = empty ? '0 : head_c[IDX_LSB +: REGIDX_W];
    assign O_WbData    = empty ? '0 : head_c[SDATA_LSB +: REG_WIDTH];
    assign O_VWbData   = empty ? '0 : head_c[VDATA_LSB +: VEC_W];
    assign O_VWbMask   = empty ? '0 : head_c[MASK_LSB +: NUM_LANES];
    assign O_RetireCnt = retire_q;

    always_comb begin
        retire_d = retire_q;
        if (accept_c && (retire_q != '1)) retire_d = retire_q + RET_W'(1);
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) retire_q <= '0;
        else            retire_q <= retire_d;
    end

`ifdef WB_FWD_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        logic [PTR_W-1:0]   slot;
        logic [ENTRY_W-1:0] e;
        O_FwdHit   = 1'b0;
        O_FwdData  = '0;
        O_VFwdData = '0;
        slot       = '0;
        e          = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot = rd_ptr + PTR_W'(i);
            e    = ent_c[slot];
            if ((count > CNT_W'(i)) && (e[ISVEC_BIT] == I_FwdIsVec) &&
                (e[IDX_LSB +: REGIDX_W] == I_FwdRegIdx)) begin
                O_FwdHit  = 1'b1;
                O_FwdData = e[SDATA_LSB +: REG_WIDTH];
                for (int l = 0; l < int'(NUM_LANES); l++) begin
                    O_VFwdData[l*REG_WIDTH +: REG_WIDTH] =
                        e[VDATA_LSB + l*REG_WIDTH +: REG_WIDTH] & {REG_WIDTH{e[MASK_LSB + l]}};
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue_unit.sv
// Randomised and directed bench for wb_queue_unit against a queue-based reference model.
// Forwarding checks are compiled in when WB_FWD_EN is defined.
module tb_wb_queue_unit;
    import wb_queue_unit_pkg::*;

    localparam int unsigned RW    = 16;
    localparam int unsigned NL    = 4;
    localparam int unsigned IW    = 6;
    localparam int unsigned DEPTH = 4;

    logic               clk, rst_n;
    logic               I_Valid, O_Ready, I_WbReady;
    logic [7:0]         I_Opcode;
    logic [IW-1:0]      I_DestRegIdx, O_WbRegIdx;
    logic [RW-1:0]      I_ALUOut, I_MemOut, O_WbData;
    logic [NL*RW-1:0]   I_VALUOut, O_VWbData;
    logic [NL-1:0]      I_LaneMask, O_VWbMask;
    logic               O_WbValid, O_WbIsVec;
    logic [2:0]         O_Pending;
    logic [15:0]        O_RetireCnt;
`ifdef WB_FWD_EN
    logic [IW-1:0]      I_FwdRegIdx;
    logic               I_FwdIsVec, O_FwdHit;
    logic [RW-1:0]      O_FwdData;
    logic [NL*RW-1:0]   O_VFwdData;
`endif

    wb_queue_unit #(.REG_WIDTH(RW), .NUM_LANES(NL), .REGIDX_W(IW), .DEPTH(DEPTH)) dut (
        .I_CLOCK(clk), .I_RESET_N(rst_n), .I_Valid(I_Valid), .O_Ready(O_Ready),
        .I_Opcode(I_Opcode), .I_DestRegIdx(I_DestRegIdx), .I_ALUOut(I_ALUOut),
        .I_MemOut(I_MemOut), .I_VALUOut(I_VALUOut), .I_LaneMask(I_LaneMask),
        .O_WbValid(O_WbValid), .I_WbReady(I_WbReady), .O_WbIsVec(O_WbIsVec),
        .O_WbRegIdx(O_WbRegIdx), .O_WbData(O_WbData), .O_VWbData(O_VWbData),
        .O_VWbMask(O_VWbMask), .O_Pending(O_Pending),
`ifdef WB_FWD_EN
        .I_FwdRegIdx(I_FwdRegIdx), .I_FwdIsVec(I_FwdIsVec), .O_FwdHit(O_FwdHit),
        .O_FwdData(O_FwdData), .O_VFwdData(O_VFwdData),
`endif
        .O_RetireCnt(O_RetireCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          isvec;
        logic [IW-1:0] idx;
        logic [RW-1:0] s;
        logic [NL*RW-1:0] v;
        logic [NL-1:0] m;
    } ent_t;

    ent_t        mq[$];
    logic [RW-1:0] popped[$];
    int unsigned mret;
    int          n_checks, n_errs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Writeback semantics straight from the opcode table.
    function automatic bit model_entry(input logic [7:0] opc, input logic [IW-1:0] idx,
                                       input logic [RW-1:0] alu, input logic [RW-1:0] mem,
                                       input logic [NL*RW-1:0] valu, input logic [NL-1:0] lm,
                                       output ent_t e);
        e = '0;
        e.idx = idx;
        case (opc)
            OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D, OP_MOV, OP_MOVI_D: begin e.s = alu; return 1; end
            OP_LDW, OP_LDB: begin e.s = mem; return 1; end
            OP_VADD, OP_VMOV, OP_VMOVI: begin e.isvec = 1; e.v = valu; e.m = '1; return 1; end
            OP_VCOMPMOV, OP_VCOMPMOVI: begin
                e.isvec = 1; e.v = valu; e.m = lm;
                return lm != '0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic check_state();
        ent_t h;
        h = '0;
        if (mq.size() > 0) h = mq[0];
        check("pending", 64'(O_Pending), 64'(mq.size()));
        check("ready",   64'(O_Ready),   64'(mq.size() < int'(DEPTH)));
        check("wbvalid", 64'(O_WbValid), 64'(mq.size() > 0));
        check("isvec",   64'(O_WbIsVec), 64'(h.isvec));
        check("regidx",  64'(O_WbRegIdx), 64'(h.idx));
        check("sdata",   64'(O_WbData),  64'(h.s));
        check("vdata",   O_VWbData,      h.v);
        check("vmask",   64'(O_VWbMask), 64'(h.m));
        check("retire",  64'(O_RetireCnt), 64'(mret));
`ifdef WB_FWD_EN
        begin
            bit hit;
            ent_t f;
            logic [NL*RW-1:0] fv;
            hit = 0; f = '0; fv = '0;
            foreach (mq[i]) if (mq[i].idx == I_FwdRegIdx && mq[i].isvec == I_FwdIsVec) begin
                hit = 1; f = mq[i];
            end
            for (int l = 0; l < int'(NL); l++)
                if (f.m[l]) fv[l*RW +: RW] = f.v[l*RW +: RW];
            check("fwdhit",  64'(O_FwdHit), 64'(hit));
            check("fwddata", 64'(O_FwdData), 64'(f.s));
            check("vfwddata", O_VFwdData, fv);
        end
`endif
    endtask

    // One clock: present inputs, advance the model by the spec's transfer rules, compare.
    task automatic step(input logic v, input logic [7:0] opc, input logic [IW-1:0] idx,
                        input logic [RW-1:0] alu, input logic [RW-1:0] mem,
                        input logic [NL*RW-1:0] valu, input logic [NL-1:0] lm,
                        input logic wbr, output logic accepted);
        ent_t e;
        bit   pushes, do_pop;
        I_Valid = v; I_Opcode = opc; I_DestRegIdx = idx; I_ALUOut = alu;
        I_MemOut = mem; I_VALUOut = valu; I_LaneMask = lm; I_WbReady = wbr;
        accepted = v && (mq.size() < int'(DEPTH));
        do_pop   = (mq.size() > 0) && wbr;
        pushes   = accepted && model_entry(opc, idx, alu, mem, valu, lm, e);
        #1;
        if (O_WbValid && wbr) popped.push_back(O_WbData);
        @(posedge clk); #1;
        if (do_pop) void'(mq.pop_front());
        if (pushes) mq.push_back(e);
        if (accepted && mret != 32'hFFFF) mret++;
        check_state();
    endtask

    task automatic idle(input logic wbr);
        logic a;
        step(1'b0, 8'h00, '0, '0, '0, '0, '0, wbr, a);
    endtask

    function automatic logic [7:0] pick_op();
        case ($urandom_range(0, 21))
            0: return OP_ADD_D;   1: return OP_ADDI_D;  2: return OP_AND_D;   3: return OP_ANDI_D;
            4: return OP_MOV;     5: return OP_MOVI_D;  6: return OP_LDB;     7: return OP_LDW;
            8: return OP_STW;     9: return OP_JMP;    10: return OP_JSR;    11: return OP_JSRR;
           12: return OP_BRZ;    13: return OP_BRNZP;  14: return OP_VADD;   15: return OP_VMOV;
           16: return OP_VMOVI;  17: return OP_VCOMPMOV; 18: return OP_VCOMPMOVI;
           19: return OP_VCOMPMOVI;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic acc;
        int   k;
        n_checks = 0; n_errs = 0; mret = 0;
        rst_n = 1'b0;
        I_Valid = 0; I_Opcode = 0; I_DestRegIdx = 0; I_ALUOut = 0; I_MemOut = 0;
        I_VALUOut = 0; I_LaneMask = 0; I_WbReady = 0;
`ifdef WB_FWD_EN
        I_FwdRegIdx = 0; I_FwdIsVec = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_state();

        // Single scalar ALU writeback.
        step(1, OP_ADD_D, 6'd3, 16'h1234, 16'h0, '0, '0, 1, acc);
        check("add_valid", 64'(O_WbValid), 64'd1);
        check("add_data", 64'(O_WbData), 64'h1234);
        check("add_idx", 64'(O_WbRegIdx), 64'd3);
        idle(1);

        // Non-writing opcodes still retire.
        step(1, OP_STW, 6'd1, 16'h1, 16'h2, '0, '0, 1, acc);
        step(1, OP_BRZ, 6'd2, 16'h1, 16'h2, '0, '0, 1, acc);
        check("nowb_valid", 64'(O_WbValid), 64'd0);
        check("nowb_retire", 64'(O_RetireCnt), 64'd3);

        // Back-pressure: fifth load is held until space frees.
        popped.delete();
        for (int i = 0; i < 5; i++) begin
            step(1, OP_LDW, 6'(10 + i), 16'h0, 16'(16'h5000 + i), '0, '0, 0, acc);
            if (i == 4) check("full_held", 64'(acc), 64'd0);
        end
        check("full_ready", 64'(O_Ready), 64'd0);
        k = 0;
        acc = 0;
        while (!acc && k < 8) begin
            step(1, OP_LDW, 6'd14, 16'h0, 16'h5004, '0, '0, 1, acc);
            k++;
        end
        check("fifth_entered", 64'(acc), 64'd1);
        k = 0;
        while (mq.size() > 0 && k < 10) begin idle(1); k++; end
        check("drain_count", 64'(popped.size()), 64'd5);
        for (int i = 0; i < 5 && i < popped.size(); i++)
            check("drain_order", 64'(popped[i]), 64'(16'h5000 + i));

        // Lane-masked component moves.
        step(1, OP_VCOMPMOVI, 6'd7, '0, '0, 64'h1111_2222_3333_4444, 4'b0100, 0, acc);
        check("vcomp_mask", 64'(O_VWbMask), 64'b0100);
        check("vcomp_vec", 64'(O_WbIsVec), 64'd1);
        step(1, OP_VCOMPMOVI, 6'd8, '0, '0, 64'h5555, 4'b0000, 0, acc);
        check("vcomp_zero_pending", 64'(O_Pending), 64'd1);
        idle(1);

        // Steady push+pop at occupancy 2 across pointer wrap.
        popped.delete();
        for (int i = 0; i < 2; i++)
            step(1, OP_ADD_D, 6'(20 + i), 16'(16'hC000 + i), '0, '0, '0, 0, acc);
        for (int i = 0; i < 10; i++) begin
            step(1, OP_ADD_D, 6'(22 + i), 16'(16'hC002 + i), '0, '0, '0, 1, acc);
            check("steady_pending", 64'(O_Pending), 64'd2);
        end
        idle(1); idle(1);
        check("steady_count", 64'(popped.size()), 64'd12);
        for (int i = 0; i < 12 && i < popped.size(); i++)
            check("steady_order", 64'(popped[i]), 64'(16'hC000 + i));

`ifdef WB_FWD_EN
        I_FwdRegIdx = 6'd5; I_FwdIsVec = 1'b0;
        step(1, OP_ADD_D, 6'd5, 16'hAAAA, '0, '0, '0, 0, acc);
        step(1, OP_ADD_D, 6'd5, 16'hBBBB, '0, '0, '0, 0, acc);
        check("fwd_hit", 64'(O_FwdHit), 64'd1);
        check("fwd_young", 64'(O_FwdData), 64'hBBBB);
`else
        step(1, OP_ADD_D, 6'd5, 16'hAAAA, '0, '0, '0, 0, acc);
        step(1, OP_ADD_D, 6'd5, 16'hBBBB, '0, '0, '0, 0, acc);
`endif
        step(1, OP_LDB, 6'd6, '0, 16'hCCCC, '0, '0, 1, acc);

        // Reset during drain drops everything immediately.
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(O_WbValid), 64'd0);
        check("rst_pending", 64'(O_Pending), 64'd0);
        check("rst_retire", 64'(O_RetireCnt), 64'd0);
`ifdef WB_FWD_EN
        check("rst_fwdhit", 64'(O_FwdHit), 64'd0);
`endif
        mq.delete(); mret = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        check_state();

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
`ifdef WB_FWD_EN
            I_FwdRegIdx = 6'($urandom_range(0, 7));
            I_FwdIsVec  = 1'($urandom_range(0, 1));
`endif
            step(1'($urandom_range(0, 9) < 7), pick_op(), 6'($urandom_range(0, 7)),
                 16'($urandom), 16'($urandom), {32'($urandom), 32'($urandom)},
                 4'($urandom), 1'($urandom_range(0, 9) < 6), acc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
